// File: rtl/jump_cmd_gen_pkg.sv
// Shared scancode constants, receive-FSM encoding and default jump heights
// for the PS/2 jump command path.
package jump_cmd_gen_pkg;

  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  localparam int unsigned DEF_TIMEOUT   = 50000;
  localparam int unsigned DEF_JUMP_LOW  = 20;
  localparam int unsigned DEF_JUMP_HIGH = 40;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/jump_cmd_gen_ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, falling-edge strobe, 11-bit frame
// FSM with odd-parity check and mid-frame timeout.
module ps2_rx_frame
  import jump_cmd_gen_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]  r_clk_s, r_dat_s;
  logic        r_clk_prev;
  rx_state_e   r_state, w_state_n;
  logic [7:0]  r_shift, w_shift_n;
  logic [2:0]  r_bit, w_bit_n;
  logic        r_par, w_par_n;
  logic [TW-1:0] r_tcnt, w_tcnt_n;
  logic        r_bv, w_bv_n;
  logic        r_err, w_err_n;
  logic        w_strobe, w_dat;

  // Lines idle high, so synchronisers reset high to avoid a phantom edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_clk_s    <= 2'b11;
      r_dat_s    <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_s    <= {r_clk_s[0], ps2_clk};
      r_dat_s    <= {r_dat_s[0], ps2_data};
      r_clk_prev <= r_clk_s[1];
    end
  end

  assign w_strobe = r_clk_prev & ~r_clk_s[1];
  assign w_dat    = r_dat_s[1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_par   <= 1'b0;
      r_tcnt  <= '0;
      r_bv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_bit   <= w_bit_n;
      r_par   <= w_par_n;
      r_tcnt  <= w_tcnt_n;
      r_bv    <= w_bv_n;
      r_err   <= w_err_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_bit_n   = r_bit;
    w_par_n   = r_par;
    w_bv_n    = 1'b0;
    w_err_n   = 1'b0;
    w_tcnt_n  = (r_state == ST_IDLE || w_strobe) ? '0 : r_tcnt + TW'(1);
    if (w_strobe) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_dat) begin
            w_state_n = ST_DATA;
            w_bit_n   = '0;
          end else begin
            w_err_n = 1'b1;
          end
        end
        ST_DATA: begin
          w_shift_n = {w_dat, r_shift[7:1]};
          w_bit_n   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_n = ST_PARITY;
        end
        ST_PARITY: begin
          w_par_n   = w_dat;
          w_state_n = ST_STOP;
        end
        ST_STOP: begin
          if (w_dat && (^{r_shift, r_par})) w_bv_n  = 1'b1;
          else                              w_err_n = 1'b1;
          w_state_n = ST_IDLE;
        end
        default: w_state_n = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE && r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      // Stalled mid-frame: drop the partial byte.
      w_state_n = ST_IDLE;
      w_err_n   = 1'b1;
      w_tcnt_n  = '0;
    end
  end

  assign rx_byte    = r_shift;
  assign byte_valid = r_bv;
  assign frame_err  = r_err;

endmodule

// File: rtl/jump_cmd_gen.sv
// PS/2 keyboard to jump command: decodes make/break/extended scancodes and
// emits one jump pulse per Space / Up-arrow press.
module jump_cmd_gen
  import jump_cmd_gen_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int unsigned HEIGHT_W       = 8,
  parameter int unsigned JUMP_LOW       = DEF_JUMP_LOW,
  parameter int unsigned JUMP_HIGH      = DEF_JUMP_HIGH
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic                jump,
  output logic [HEIGHT_W-1:0] jump_height,
  output logic                key_held,
  output logic                frame_err
);

  logic [7:0]          w_byte;
  logic                w_bv, w_err;
  logic                w_space, w_up;
  logic                r_ext, r_brk, r_held, r_jump;
  logic [HEIGHT_W-1:0] r_height;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clock      (clock),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (w_byte),
    .byte_valid (w_bv),
    .frame_err  (w_err)
  );

  assign w_space = !r_ext && (w_byte == SC_SPACE);
  assign w_up    =  r_ext && (w_byte == SC_UP);

  // One held flag covers both keys: releasing either clears it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_held   <= 1'b0;
      r_jump   <= 1'b0;
      r_height <= '0;
    end else begin
      r_jump <= 1'b0;
      if (w_err) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_bv) begin
        if (w_byte == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == SC_BRK) begin
          r_brk <= 1'b1;
        end else begin
          if (!r_brk) begin
            if ((w_space || w_up) && !r_held) begin
              r_jump   <= 1'b1;
              r_height <= w_up ? HEIGHT_W'(JUMP_HIGH) : HEIGHT_W'(JUMP_LOW);
              r_held   <= 1'b1;
            end
          end else if (w_space || w_up) begin
            r_held <= 1'b0;
          end
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end

  assign jump        = r_jump;
  assign jump_height = r_height;
  assign key_held    = r_held;
  assign frame_err   = w_err;

endmodule

// File: tb/tb_jump_cmd_gen.sv
// Bench for jump_cmd_gen: table of PS/2 frames with expected pulses/state,
// a height scoreboard fed at stimulus time, plus timing/timeout/reset cases.
module tb_jump_cmd_gen;

  localparam int H = 8;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       jump, key_held, frame_err;
  logic [7:0] jump_height;

  int total = 0;
  int bad = 0;
  int jmp_seen = 0;
  int err_seen = 0;
  logic [7:0] sb_q[$];
  logic prev_jump = 1'b0;

  jump_cmd_gen dut (
    .clock       (clock),
    .resetn      (resetn),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .jump        (jump),
    .jump_height (jump_height),
    .key_held    (key_held),
    .frame_err   (frame_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every jump pulse pops the height queued when the frame was sent.
  always @(negedge clock) begin
    if (!resetn) begin
      prev_jump <= 1'b0;
    end else begin
      if (frame_err) err_seen++;
      if (jump) begin
        jmp_seen++;
        chk("jump_not_back_to_back", int'(prev_jump), 0);
        if (sb_q.size() == 0) begin
          chk("unexpected_jump", 1, 0);
        end else begin
          chk("jump_height", int'(jump_height), int'(sb_q.pop_front()));
        end
      end
      prev_jump <= jump;
    end
  end

  // Sends the first nbits bits of a frame; chk_lat verifies jump timing
  // relative to the stop-bit falling edge.
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int nbits, input bit chk_lat);
    logic [10:0] f;
    logic p;
    p = bad_par ? (^b) : ~(^b);
    f = {1'b1, p, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      @(negedge clock);
      ps2_data = f[k];
      repeat (H) @(negedge clock);
      ps2_clk = 1'b0;
      for (int i = 0; i < H; i++) begin
        @(posedge clock);
        #1;
        if (chk_lat && k == 10 && i == 2) chk("lat_jump_early", int'(jump), 0);
        if (chk_lat && k == 10 && i == 3) chk("lat_jump_on_time", int'(jump), 1);
      end
      @(negedge clock);
      ps2_clk = 1'b1;
    end
    @(negedge clock);
    ps2_data = 1'b1;
  endtask

  typedef struct {
    logic [7:0] code;
    bit         badp;
    int         jmp;
    logic [7:0] h;
    int         held;
    int         err;
  } vec_t;

  vec_t tbl[$];

  task automatic run_frame(input logic [7:0] code, input bit badp, input int ejmp,
                           input logic [7:0] eh, input int eheld, input int eerr,
                           input bit lat, input string tag);
    int jc, ec;
    jc = jmp_seen;
    ec = err_seen;
    if (ejmp != 0) sb_q.push_back(eh);
    send_frame(code, badp, 11, lat);
    repeat (20) @(negedge clock);
    chk({tag, "_jumps"}, jmp_seen - jc, ejmp);
    chk({tag, "_errs"}, err_seen - ec, eerr);
    chk({tag, "_held"}, int'(key_held), eheld);
  endtask

  initial begin
    int jc, ec;
    tbl.push_back('{8'h29, 1'b0, 1, 8'd20, 1, 0});
    tbl.push_back('{8'h29, 1'b0, 0, 8'd0,  1, 0});
    tbl.push_back('{8'h29, 1'b0, 0, 8'd0,  1, 0});
    tbl.push_back('{8'hF0, 1'b0, 0, 8'd0,  1, 0});
    tbl.push_back('{8'h29, 1'b0, 0, 8'd0,  0, 0});
    tbl.push_back('{8'hE0, 1'b0, 0, 8'd0,  0, 0});
    tbl.push_back('{8'h75, 1'b0, 1, 8'd40, 1, 0});
    tbl.push_back('{8'hE0, 1'b0, 0, 8'd0,  1, 0});
    tbl.push_back('{8'hF0, 1'b0, 0, 8'd0,  1, 0});
    tbl.push_back('{8'h75, 1'b0, 0, 8'd0,  0, 0});
    tbl.push_back('{8'h29, 1'b1, 0, 8'd0,  0, 1});
    tbl.push_back('{8'h29, 1'b0, 1, 8'd20, 1, 0});
    tbl.push_back('{8'hE0, 1'b0, 0, 8'd0,  1, 0});
    tbl.push_back('{8'h75, 1'b0, 0, 8'd0,  1, 0});
    tbl.push_back('{8'hE0, 1'b0, 0, 8'd0,  1, 0});
    tbl.push_back('{8'hF0, 1'b0, 0, 8'd0,  1, 0});
    tbl.push_back('{8'h75, 1'b0, 0, 8'd0,  0, 0});
    tbl.push_back('{8'hF0, 1'b0, 0, 8'd0,  0, 0});
    tbl.push_back('{8'h29, 1'b0, 0, 8'd0,  0, 0});
    tbl.push_back('{8'h12, 1'b0, 0, 8'd0,  0, 0});
    tbl.push_back('{8'hE0, 1'b0, 0, 8'd0,  0, 0});
    tbl.push_back('{8'h29, 1'b0, 0, 8'd0,  0, 0});
    tbl.push_back('{8'h75, 1'b0, 0, 8'd0,  0, 0});
    tbl.push_back('{8'hE0, 1'b0, 0, 8'd0,  0, 0});
    tbl.push_back('{8'h75, 1'b1, 0, 8'd0,  0, 1});
    tbl.push_back('{8'h75, 1'b0, 0, 8'd0,  0, 0});

    repeat (3) @(negedge clock);
    chk("rst_jump", int'(jump), 0);
    chk("rst_height", int'(jump_height), 0);
    chk("rst_held", int'(key_held), 0);
    chk("rst_err", int'(frame_err), 0);
    resetn = 1'b1;
    repeat (5) @(negedge clock);

    for (int i = 0; i < tbl.size(); i++)
      run_frame(tbl[i].code, tbl[i].badp, tbl[i].jmp, tbl[i].h, tbl[i].held,
                tbl[i].err, 1'b0, $sformatf("vec%0d", i));

    run_frame(8'h29, 1'b0, 1, 8'd20, 1, 0, 1'b1, "latency");
    run_frame(8'hF0, 1'b0, 0, 8'd0, 1, 0, 1'b0, "rel_brk");
    run_frame(8'h29, 1'b0, 0, 8'd0, 0, 0, 1'b0, "rel_space");

    // Stall after start + 4 data bits.
    ec = err_seen;
    jc = jmp_seen;
    send_frame(8'h29, 1'b0, 5, 1'b0);
    repeat (50100) @(negedge clock);
    chk("timeout_err", err_seen - ec, 1);
    chk("timeout_jumps", jmp_seen - jc, 0);
    run_frame(8'h29, 1'b0, 1, 8'd20, 1, 0, 1'b0, "after_timeout");

    // A clock pulse with data high while idle is a bad start bit.
    ec = err_seen;
    send_frame(8'hFF, 1'b0, 0, 1'b0);
    @(negedge clock);
    ps2_data = 1'b1;
    repeat (H) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clock);
    chk("bad_start_err", err_seen - ec, 1);
    chk("bad_start_held", int'(key_held), 1);

    // Reset mid-frame while a key is held.
    send_frame(8'h29, 1'b0, 3, 1'b0);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("midrst_jump", int'(jump), 0);
    chk("midrst_height", int'(jump_height), 0);
    chk("midrst_held", int'(key_held), 0);
    chk("midrst_err", int'(frame_err), 0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(negedge clock);
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    run_frame(8'h29, 1'b0, 1, 8'd20, 1, 0, 1'b0, "after_reset");

    chk("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
